// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and default widths for the instruction fetch unit
//
// Purpose : default address/instruction widths, fetch FSM state encoding and
//           the prefetch FIFO entry layout shared by imem_fetch and fetch_fifo.
// Ports   : none (package).
package fetch_pkg;

    localparam int ADDR_W_DEF  = 6;
    localparam int INSTR_W_DEF = 32;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [ADDR_W_DEF-1:0]  addr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO: circular buffer with registered head, no bypass
//
// Purpose : holds fetched {instr, addr} entries between the imem read and decode.
// Ports   : clk, reset (async, active-low)
//           push/wdata  write an entry at the tail (accepted when not full, or
//                       when full and a pop happens in the same cycle)
//           pop         remove the head (ignored when empty)
//           clear       drop all entries; dominates push/pop
//           rdata       head entry, zero when empty
//           full/empty/count  occupancy status
// DEPTH must be a power of two (pointers wrap by natural overflow) and >= 2.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 wdata,
    input  logic                   pop,
    input  logic                   clear,
    output entry_t                 rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_do_pop;
    logic               w_do_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));
    assign count = r_count;

    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Empty head reads as zero so stale or unwritten storage never leaks out.
    assign rdata = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push && !clear) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/imem.sv
// rtl/imem.sv - combinational instruction ROM (6-bit word address, 32-bit data)
//
// Purpose : program image read by imem_fetch; the all-zero word at address 47
//           marks the end of the program.
// Ports   : addr (in, 6)  word address
//           q    (out, 32) instruction word, combinational from addr
module imem (
    input  logic [5:0]  addr,
    output logic [31:0] q
);

    always_comb begin
        case (addr)
            6'd0:    q = 32'hf8000001;
            6'd1:    q = 32'hf8008002;
            6'd2:    q = 32'hf8000203;
            6'd29:   q = 32'hb4000040;
            6'd30:   q = 32'hf8080015;
            6'd37:   q = 32'hb4ffff82;
            6'd38:   q = 32'hf809001e;
            6'd46:   q = 32'hb400001f;
            6'd47:   q = 32'h00000000;
            // Filler program words; never zero so only address 47 ends the program.
            default: q = {8'he0, 18'h0, addr};
        endcase
    end

endmodule

// File: rtl/imem_fetch.sv
// rtl/imem_fetch.sv - instruction fetch: PC, run/halt FSM, prefetch FIFO to decode
//
// Purpose : addresses the combinational imem with a registered PC, pushes each
//           returned word with its address into a prefetch FIFO, halts on the
//           all-zero end-of-program word and restarts on a redirect.
// Ports   : clk, reset (async, active-low)
//           imem_addr/imem_q           imem read interface
//           instr/instr_addr/instr_valid/instr_ready  head of FIFO to decode
//           redirect_valid/redirect_addr  flush and restart at a new address
//           done                       fetch halted on a zero word
//           occupancy                  FIFO entry count
module imem_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int INSTR_W      = INSTR_W_DEF,
    parameter int DEPTH        = 4,
    parameter int RESET_ADDR   = 0,
    parameter bit HALT_ON_ZERO = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic [INSTR_W-1:0]     imem_q,
    output logic [INSTR_W-1:0]     instr,
    output logic [ADDR_W-1:0]      instr_addr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_addr,
    output logic                   done,
    output logic [$clog2(DEPTH):0] occupancy
);

    // Entry layout follows fetch_entry_t but tracks this instance's widths.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  addr;
    } entry_t;

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic               r_done;
    logic               w_done_nxt;

    logic               w_push;
    logic               w_pop;
    logic               w_fifo_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_end_word;
    entry_t             w_wdata;
    entry_t             w_head;

    assign w_pop      = !w_empty && instr_ready;
    // A redirect clears the FIFO, so a handshake in that cycle is void.
    assign w_fifo_pop = w_pop && !redirect_valid;
    assign w_end_word = HALT_ON_ZERO && (imem_q == '0);

    assign w_wdata.instr = imem_q;
    assign w_wdata.addr  = r_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_pc    <= ADDR_W'(RESET_ADDR);
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_done_nxt  = r_done;
        w_push      = 1'b0;

        if (redirect_valid) begin
            w_state_nxt = RUN;
            w_pc_nxt    = redirect_addr;
            w_done_nxt  = 1'b0;
        end else if (r_state == RUN && (!w_full || w_pop)) begin
            if (w_end_word) begin
                // End marker is consumed but not queued; PC stays on it.
                w_state_nxt = HALT;
                w_done_nxt  = 1'b1;
            end else begin
                w_push   = 1'b1;
                w_pc_nxt = r_pc + ADDR_W'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .wdata (w_wdata),
        .pop   (w_fifo_pop),
        .clear (redirect_valid),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (occupancy)
    );

    assign imem_addr   = r_pc;
    assign instr       = w_head.instr;
    assign instr_addr  = w_head.addr;
    assign instr_valid = !w_empty;
    assign done        = r_done;

endmodule

// File: doc/imem_fetch.md
Name: imem_fetch

Overview:
- Initiator side of the instruction-memory read interface: drives the word address into the combinational `imem` ROM (6-bit address, 32-bit data) and captures the returned word.
- Buffers fetched words in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Supports a redirect (branch-taken) flush, and halts fetch when it reads the all-zero word that marks the end of the program.

Parameters:
- ADDR_W, 6, word-address width; matches the imem addr port.
- INSTR_W, 32, instruction width; matches imem q.
- DEPTH, 4, prefetch FIFO entries; must be a power of 2 and at least 2.
- RESET_ADDR, 0, word address fetched first after reset.
- HALT_ON_ZERO, 1, if 1, a fetched word equal to 0 halts fetch.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_addr  out  ADDR_W  word address to imem; registered (PC).
- imem_q  in  INSTR_W  imem read data; combinational from imem_addr, same cycle.
- instr  out  INSTR_W  FIFO head instruction.
- instr_addr  out  ADDR_W  word address of the FIFO head.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode accepts the head.
- redirect_valid  in  1  flush and restart fetch.
- redirect_addr  in  ADDR_W  new fetch word address.
- done  out  1  fetch halted on a zero word.
- occupancy  out  $clog2(DEPTH)+1  FIFO entry count.

Behaviour:
- Reset (async, reset=0) puts the block in this state:
  - imem_addr=RESET_ADDR; state=RUN.
  - FIFO empty; instr_valid=0; instr=0; instr_addr=0.
  - done=0; occupancy=0.
- States: RUN, HALT.
- pop = instr_valid && instr_ready.
- push (RUN only) happens when the FIFO is not full, or is full and pop occurs this cycle.
- push with imem_q != 0, or with HALT_ON_ZERO=0:
  - write {imem_q, imem_addr} to the FIFO tail.
  - imem_addr <= imem_addr+1, wrapping 2^ADDR_W-1 -> 0.
- push with imem_q == 0 and HALT_ON_ZERO=1:
  - the word is not written to the FIFO.
  - state <= HALT; done <= 1; imem_addr holds.
- FIFO full and no pop: no push, and imem_addr holds.
- HALT: no fetch. The FIFO keeps draining normally through pop.
- Latency: a word addressed in cycle N is visible at the FIFO head at cycle N+1 at the earliest (registered FIFO, no bypass).
- Sustained throughput is 1 instr/cycle with instr_ready=1.
- FIFO behaviour:
  - head outputs are stable while instr_valid=1 and instr_ready=0.
  - simultaneous push and pop when full is allowed; occupancy is unchanged.
  - simultaneous push and pop when empty: the pushed word appears next cycle.
- Redirect has the highest priority. In the redirect cycle:
  - FIFO cleared; any pop/push in that cycle is discarded.
  - imem_addr <= redirect_addr; state <= RUN; done <= 0.
  - instr_valid=0 in the following cycle.
  - the first redirected word is valid 2 cycles after the redirect edge.
- Redirect during HALT restarts fetch.
- Reset asserted mid-operation: immediately returns all outputs to reset values, independent of clk.
- instr and instr_addr when instr_valid=0: must be held at the last value or zeroed, never X after reset.

Decomposition:
- Shared package `fetch_pkg`:
  - ADDR_W and INSTR_W defaults.
  - typedef `fetch_state_t` enum {RUN, HALT}.
  - typedef `fetch_entry_t` packed struct {instr, addr}.
- One sub-module, `fetch_fifo`:
  - parameterised DEPTH and entry type.
  - signals: push, pop, clear, full, empty, count.
  - circular buffer with wrap-around read/write pointers.
- `imem_fetch` holds the PC, state machine and push/halt logic, and instantiates `fetch_fifo`.
- Bench connects the real `imem`.

Test Plan:
- Reset release, instr_ready=1 → cycle 1: instr=f8000001, addr 0. Cycle 2: f8008002, addr 1. Cycle 3: f8000203, addr 2.
- Free run to end → last valid instr=b400001f at addr 46. Zero word at addr 47 → done=1, imem_addr stays 47, no further instr_valid after the FIFO drains.
- Backpressure: instr_ready=0 from reset → occupancy reaches 4, imem_addr stops at 4, head holds f8000001. Raise instr_ready → addresses 0..4 delivered in order with none lost.
- Redirect to 29 with the FIFO holding 3 entries → FIFO flushed. Next valid instr=b4000040, addr 29, followed by f8080015 (addr 30).
- Redirect to 37 while in HALT → done=0, fetch resumes: b4ffff82 (addr 37), then f809001e (addr 38).
- Assert reset between clock edges with the FIFO at 2 entries → instr_valid=0, occupancy=0, imem_addr=0 immediately. After release, fetch restarts from f8000001.
